dma_channel_arbiter: RTL and testbench
======================================

DMA_CHANNEL_ARBITER -- requirements
Module: dma_channel_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, number of DMA channels; legal range 2..8.
REQ-002 Parameter CHW, default $clog2(NUM_CH), width of the channel index.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 DREQ  input  NUM_CH  per-channel DMA request, active-high.
REQ-006 HLDA  input  1  hold acknowledge from the CPU.
REQ-007 priorityType  input  1  0 = fixed priority, 1 = rotating priority.
REQ-008 ctrlDisable  input  1  controller disable; blocks new requests.
REQ-009 maskWrite  input  1  one-cycle strobe that loads the mask register from maskData.
REQ-010 maskData  input  NUM_CH  new mask value; 1 = channel masked.
REQ-011 transferDone  input  1  one-cycle pulse from timing control marking the end of the granted transfer.
REQ-012 tcIn  input  1  terminal count of the granted channel; qualified by transferDone.
REQ-013 HRQ  output  1  hold request to the CPU, registered.
REQ-014 DACK  output  NUM_CH  one-hot acknowledge, active-high, registered.
REQ-015 grantValid  output  1  high while DACK is non-zero.
REQ-016 grantChannel  output  CHW  index of the granted channel; 0 when grantValid is low.
REQ-017 maskReg  output  NUM_CH  current mask register.

Function
REQ-018 The effective request SHALL be DREQ & ~maskReg, forced to 0 while ctrlDisable is high.
REQ-019 The block SHALL implement the states IDLE, HOLD_REQ, ACTIVE and RELEASE.
REQ-020 IDLE: HRQ=0 and DACK=0; any non-zero effective request -> HOLD_REQ, with HRQ=1 on the next cycle.
REQ-021 HOLD_REQ: HRQ held at 1; HLDA=1 -> the winner is latched from the effective requests of that same cycle -> ACTIVE, with DACK one-hot on the next cycle.
REQ-022 HOLD_REQ: if the effective request is 0 and HLDA=0 -> IDLE, with HRQ=0 on the next cycle.
REQ-023 ACTIVE: HRQ and DACK are held and the grant is locked; DREQ changes are ignored.
REQ-024 ACTIVE with transferDone=1 -> RELEASE; if priorityType=1, the rotation pointer SHALL become (granted channel + 1) mod NUM_CH.
REQ-025 ACTIVE with HLDA=0 -> IDLE (abort); HRQ=0 and DACK=0 next cycle; the pointer is unchanged.
REQ-026 ACTIVE with both HLDA=0 and transferDone=1 SHALL be treated as a normal completion, not an abort.
REQ-027 RELEASE: HRQ=0 and DACK=0 for exactly one cycle -> IDLE.
REQ-028 Fixed priority: channel 0 is highest and NUM_CH-1 is lowest; the pointer is forced to 0 while priorityType=0.
REQ-029 Rotating priority: the channel at the pointer is highest, and priority descends with index modulo NUM_CH.
REQ-030 A maskWrite SHALL take effect on the next cycle, and SHALL NOT revoke a grant already in ACTIVE.
REQ-031 Minimum latency: effective request at cycle t -> HRQ at t+1; HLDA at cycle t -> DACK at t+1.

Reset
REQ-032 While RESET=1, on the next edge the block SHALL set: state IDLE, HRQ=0, DACK=0, grantValid=0, grantChannel=0, maskReg all ones, pointer 0.
REQ-033 RESET SHALL override every other input in any state, including mid-ACTIVE.

Configuration
REQ-034 Macro AUTO_MASK_ON_TC_EN defined: transferDone=1 with tcIn=1 in ACTIVE SHALL set maskReg[grantChannel] on the next cycle.
REQ-035 If a maskWrite occurs in the same cycle as that auto-mask event, the new mask SHALL be maskData with the auto-mask bit ORed in.
REQ-036 Macro not defined: tcIn SHALL be ignored, and maskReg changes only through maskWrite and RESET.

Structure
REQ-037 Package dma_arb_pkg SHALL hold the state enum (IDLE, HOLD_REQ, ACTIVE, RELEASE), the priority-type constants FIXED=0 and ROTATING=1, and a one-hot-to-index function.
REQ-038 Sub-module dma_priority_encoder SHALL be combinational, with inputs request vector and pointer, and outputs valid and winner index.
REQ-039 The FSM, mask register and pointer SHALL reside in dma_channel_arbiter.

Verification (NUM_CH=4)
REQ-040 Reset; maskWrite 0000; fixed; DREQ=0011; HLDA raised after HRQ -> DACK=0001, grantChannel=0.
REQ-041 Rotating; DREQ=1111 held; four transferDone pulses -> DACK sequence 0001,0010,0100,1000, then 0001.
REQ-042 DREQ=1110; fixed; HLDA=1 -> DACK=0010; then HLDA dropped in ACTIVE -> DACK=0000 next cycle, and the pointer is unchanged.
REQ-043 DREQ=0100 raised then withdrawn before HLDA -> HRQ returns to 0, state IDLE, and DACK stays 0000.
REQ-044 Channel 2 granted; transferDone with tcIn=1 -> with AUTO_MASK_ON_TC_EN, maskReg=0100 and a held DREQ=0100 gives no new HRQ; without the macro, HRQ rises again.
REQ-045 RESET asserted mid-ACTIVE -> next cycle HRQ=0, DACK=0000, maskReg=1111, pointer=0.

Source files
------------

// File: rtl/dma_channel_arbiter_pkg.sv
// Shared types for the DMA channel arbiter.
// State encoding, priority-type constants and a one-hot decoder.
package dma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD_REQ,
    ACTIVE,
    RELEASE
  } arb_state_e;

  localparam logic FIXED    = 1'b0;
  localparam logic ROTATING = 1'b1;

  function automatic logic [2:0] onehot_to_idx(
    input logic [7:0] oh
  );
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dma_channel_arbiter_if.sv
// Request/acknowledge bundle between the DMA channels, CPU and arbiter.
// The arbiter takes the slave side; the channel/CPU model takes master.
interface dma_channel_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int CHW    = $clog2(NUM_CH)
) ();

  logic [NUM_CH-1:0] DREQ;
  logic              HLDA;
  logic              priorityType;
  logic              ctrlDisable;
  logic              maskWrite;
  logic [NUM_CH-1:0] maskData;
  logic              transferDone;
  logic              tcIn;
  logic              HRQ;
  logic [NUM_CH-1:0] DACK;
  logic              grantValid;
  logic [CHW-1:0]    grantChannel;
  logic [NUM_CH-1:0] maskReg;

  modport slave (
    input  DREQ, HLDA, priorityType, ctrlDisable,
    input  maskWrite, maskData, transferDone, tcIn,
    output HRQ, DACK, grantValid, grantChannel, maskReg
  );

  modport master (
    output DREQ, HLDA, priorityType, ctrlDisable,
    output maskWrite, maskData, transferDone, tcIn,
    input  HRQ, DACK, grantValid, grantChannel, maskReg
  );

endinterface

// File: rtl/dma_channel_arbiter_enc.sv
// Combinational rotating-start priority encoder.
// The channel at ptr wins first; priority descends with index mod NUM_CH.
module dma_priority_encoder #(
  parameter int NUM_CH = 4,
  parameter int CHW    = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CHW-1:0]    ptr,
  output logic              valid,
  output logic [CHW-1:0]    winner
);

  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  logic [CHW:0]        sum;

  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NUM_CH-1:0];

  // Walk from lowest priority up so the highest one is written last.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, ptr} + (CHW+1)'(i);
        if (sum >= (CHW+1)'(NUM_CH))
          sum = sum - (CHW+1)'(NUM_CH);
        valid  = 1'b1;
        winner = sum[CHW-1:0];
      end
    end
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// DMA channel arbiter: HRQ/HLDA hold handshake, fixed or rotating grant.
// Define AUTO_MASK_ON_TC_EN to mask a channel when it reaches terminal count.
module dma_channel_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CHW    = $clog2(NUM_CH)
) (
  input logic CLK,
  input logic RESET,
  dma_channel_arbiter_if.slave bus
);

  arb_state_e        state, state_n;
  logic              hrq_q, hrq_n;
  logic [NUM_CH-1:0] dack_q, dack_n;
  logic [NUM_CH-1:0] mask_q, eff, auto_bits;
  logic [CHW-1:0]    ptr_q, enc_ptr, win, gidx, ptr_wrap;
  logic [CHW:0]      ptr_inc;
  logic              win_valid, done_evt;

  assign eff = bus.ctrlDisable ? '0
             : (bus.DREQ & ~mask_q);
  assign enc_ptr = (bus.priorityType == ROTATING)
                 ? ptr_q : '0;

  dma_priority_encoder #(
    .NUM_CH (NUM_CH),
    .CHW    (CHW)
  ) u_enc (
    .req    (eff),
    .ptr    (enc_ptr),
    .valid  (win_valid),
    .winner (win)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      hrq_q  <= 1'b0;
      dack_q <= '0;
    end else begin
      state  <= state_n;
      hrq_q  <= hrq_n;
      dack_q <= dack_n;
    end
  end

  // transferDone wins over a dropped HLDA: completion, not abort.
  always_comb begin
    state_n = state;
    dack_n  = dack_q;
    unique case (state)
      IDLE:
        if (|eff) state_n = HOLD_REQ;
      HOLD_REQ:
        if (bus.HLDA && win_valid) begin
          state_n = ACTIVE;
          dack_n  = NUM_CH'(1) << win;
        end else if (!(|eff)) begin
          state_n = IDLE;
        end
      ACTIVE:
        if (bus.transferDone)  state_n = RELEASE;
        else if (!bus.HLDA)    state_n = IDLE;
      RELEASE:
        state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
    hrq_n = (state_n == HOLD_REQ) ||
            (state_n == ACTIVE);
    if (state_n != ACTIVE) dack_n = '0;
  end

  assign gidx     = CHW'(onehot_to_idx(8'(dack_q)));
  assign done_evt = (state == ACTIVE) && bus.transferDone;
  assign ptr_inc  = {1'b0, gidx} + 1'b1;
  assign ptr_wrap = (ptr_inc >= (CHW+1)'(NUM_CH))
                  ? '0 : ptr_inc[CHW-1:0];

  always_ff @(posedge CLK) begin
    if (RESET)
      ptr_q <= '0;
    else if (bus.priorityType == FIXED)
      ptr_q <= '0;
    else if (done_evt)
      ptr_q <= ptr_wrap;
  end

`ifdef AUTO_MASK_ON_TC_EN
  assign auto_bits = (done_evt && bus.tcIn)
                   ? dack_q : '0;
`else
  logic tc_unused;
  assign tc_unused = bus.tcIn;
  assign auto_bits = '0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET)
      mask_q <= '1;
    else if (bus.maskWrite)
      mask_q <= bus.maskData | auto_bits;
    else
      mask_q <= mask_q | auto_bits;
  end

  assign bus.HRQ          = hrq_q;
  assign bus.DACK         = dack_q;
  assign bus.grantValid   = |dack_q;
  assign bus.grantChannel = gidx;
  assign bus.maskReg      = mask_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed scoreboard bench for dma_channel_arbiter with NUM_CH=4.
// Stimulus queues cycle-tagged expectations; a negedge monitor checks them.
module tb_dma_channel_arbiter;

`ifdef AUTO_MASK_ON_TC_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif

  typedef struct {
    int         cyc;
    string      nm;
    logic       hrq;
    logic [3:0] dack;
    logic [1:0] gch;
    logic [3:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   fails = 0;
  exp_t sb[$];

  dma_channel_arbiter_if #(.NUM_CH(4)) bus ();

  dma_channel_arbiter #(.NUM_CH(4)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [9:0] got, want;
      e = sb.pop_front();
      got  = {bus.HRQ, bus.grantValid, bus.DACK,
              bus.grantChannel, bus.maskReg[1:0]};
      want = {e.hrq, |e.dack, e.dack,
              e.gch, e.mask[1:0]};
      vectors++;
      if (got !== want || bus.maskReg !== e.mask) begin
        fails++;
        $display("FAIL %s cyc=%0d got hrq=%b gv=%b dack=%b gch=%0d mask=%b want hrq=%b gv=%b dack=%b gch=%0d mask=%b",
          e.nm, cyc, bus.HRQ, bus.grantValid, bus.DACK,
          bus.grantChannel, bus.maskReg, e.hrq, |e.dack,
          e.dack, e.gch, e.mask);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int d,
                     input logic hrq, input logic [3:0] dack,
                     input logic [1:0] gch, input logic [3:0] mask);
    exp_t e;
    e.cyc = cyc + d; e.nm = nm; e.hrq = hrq;
    e.dack = dack; e.gch = gch; e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic quiesce();
    bus.DREQ = '0; bus.HLDA = 1'b0;
    bus.transferDone = 1'b0; bus.tcIn = 1'b0;
    bus.maskWrite = 1'b0;
    tick(3);
  endtask

  initial begin
    logic [3:0] mexp;
    rst = 1'b1;
    bus.DREQ = '0; bus.HLDA = 1'b0;
    bus.priorityType = 1'b0; bus.ctrlDisable = 1'b0;
    bus.maskWrite = 1'b0; bus.maskData = '0;
    bus.transferDone = 1'b0; bus.tcIn = 1'b0;
    tick(2);
    chk("reset", 0, 0, 4'b0000, 0, 4'b1111);
    rst = 1'b0;
    bus.maskWrite = 1'b1; bus.maskData = 4'b0000;
    chk("mask_clear", 1, 0, 4'b0000, 0, 4'b0000);
    tick; bus.maskWrite = 1'b0;

    // fixed priority, lowest index wins, grant locked
    bus.DREQ = 4'b0011;
    chk("hrq_rise", 1, 1, 4'b0000, 0, 4'b0000); tick;
    bus.HLDA = 1'b1;
    chk("grant_fix", 1, 1, 4'b0001, 0, 4'b0000); tick;
    bus.DREQ = 4'b0010;
    chk("grant_lock", 1, 1, 4'b0001, 0, 4'b0000); tick;
    bus.transferDone = 1'b1;
    chk("release", 1, 0, 4'b0000, 0, 4'b0000); tick;
    bus.transferDone = 1'b0;
    quiesce();

    bus.ctrlDisable = 1'b1; bus.DREQ = 4'b1111;
    chk("disable", 1, 0, 4'b0000, 0, 4'b0000); tick;
    chk("disable2", 1, 0, 4'b0000, 0, 4'b0000); tick;
    bus.ctrlDisable = 1'b0; bus.DREQ = '0; tick;

    bus.maskWrite = 1'b1; bus.maskData = 4'b0001;
    chk("mask_set", 1, 0, 4'b0000, 0, 4'b0001); tick;
    bus.maskWrite = 1'b0; bus.DREQ = 4'b0001;
    chk("masked", 1, 0, 4'b0000, 0, 4'b0001); tick;
    chk("masked2", 1, 0, 4'b0000, 0, 4'b0001); tick;
    bus.DREQ = '0; bus.maskWrite = 1'b1; bus.maskData = '0;
    tick; bus.maskWrite = 1'b0;

    // rotating sequence over all channels
    bus.priorityType = 1'b1; bus.DREQ = 4'b1111; bus.HLDA = 1'b1;
    chk("rot_hrq", 1, 1, 4'b0000, 0, 4'b0000); tick;
    tick;
    for (int k = 0; k < 5; k++) begin
      chk("rot_grant", 0, 1, 4'(1 << (k % 4)), 2'(k % 4), 4'b0000);
      bus.transferDone = 1'b1;
      chk("rot_release", 1, 0, 4'b0000, 0, 4'b0000); tick;
      bus.transferDone = 1'b0;
      if (k < 4) tick(3);
    end
    quiesce();

    // rotating abort leaves pointer at 1
    bus.DREQ = 4'b0100; bus.HLDA = 1'b1; tick;
    chk("rabort_grant", 1, 1, 4'b0100, 2, 4'b0000); tick;
    bus.HLDA = 1'b0;
    chk("rabort_drop", 1, 0, 4'b0000, 0, 4'b0000); tick;
    bus.DREQ = 4'b1111; bus.HLDA = 1'b1; tick;
    chk("rabort_ptr", 1, 1, 4'b0010, 1, 4'b0000); tick;
    quiesce();

    bus.priorityType = 1'b0;
    bus.DREQ = 4'b1110; bus.HLDA = 1'b1; tick;
    chk("fix_grant1", 1, 1, 4'b0010, 1, 4'b0000); tick;
    bus.HLDA = 1'b0;
    chk("fix_abort", 1, 0, 4'b0000, 0, 4'b0000); tick;
    quiesce();

    bus.DREQ = 4'b0100;
    chk("wd_hrq", 1, 1, 4'b0000, 0, 4'b0000); tick;
    bus.DREQ = '0;
    chk("wd_idle", 1, 0, 4'b0000, 0, 4'b0000); tick;
    chk("wd_stay", 1, 0, 4'b0000, 0, 4'b0000); tick;

    // terminal count with a simultaneous mask write
    mexp = AUTO ? 4'b0101 : 4'b0001;
    bus.DREQ = 4'b0100; bus.HLDA = 1'b1; tick;
    chk("tc_grant", 1, 1, 4'b0100, 2, 4'b0000); tick;
    bus.transferDone = 1'b1; bus.tcIn = 1'b1; bus.HLDA = 1'b0;
    bus.maskWrite = 1'b1; bus.maskData = 4'b0001;
    chk("tc_mask", 1, 0, 4'b0000, 0, mexp); tick;
    bus.transferDone = 1'b0; bus.tcIn = 1'b0; bus.maskWrite = 1'b0;
    chk("tc_idle", 1, 0, 4'b0000, 0, mexp);
    chk("tc_rereq", 2, !AUTO, 4'b0000, 0, mexp);
    tick(2);
    quiesce();
    bus.maskWrite = 1'b1; bus.maskData = '0; tick;
    bus.maskWrite = 1'b0;

    // reset mid-ACTIVE with pointer at 1
    bus.priorityType = 1'b1; bus.DREQ = 4'b0001; bus.HLDA = 1'b1; tick;
    chk("pre_grant0", 1, 1, 4'b0001, 0, 4'b0000); tick;
    bus.transferDone = 1'b1; tick;
    bus.transferDone = 1'b0; bus.DREQ = 4'b0010; tick(3);
    chk("pre_grant1", 0, 1, 4'b0010, 1, 4'b0000);
    bus.maskWrite = 1'b1; bus.maskData = 4'b0010;
    chk("mask_live", 1, 1, 4'b0010, 1, 4'b0010); tick;
    bus.maskWrite = 1'b0; rst = 1'b1;
    chk("mid_reset", 1, 0, 4'b0000, 0, 4'b1111); tick;
    rst = 1'b0; bus.DREQ = 4'b1111;
    bus.maskWrite = 1'b1; bus.maskData = '0;
    chk("post_mask", 1, 0, 4'b0000, 0, 4'b0000); tick;
    bus.maskWrite = 1'b0;
    chk("post_hrq", 1, 1, 4'b0000, 0, 4'b0000); tick;
    chk("post_ptr0", 1, 1, 4'b0001, 0, 4'b0000); tick;
    quiesce();

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      $display("FAIL drain %0d expectations never checked", sb.size());
      fails += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
